serial_cmp_ctrl: RTL and testbench

//  Sequencer that compares two WIDTH-bit unsigned operands using one external 2-bit

---
 rtl/serial_cmp_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_cmp_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl: compares two WIDTH-bit unsigned operands through one
// external 2-bit comparator slice. Slices are scanned starting at the MSB,
// with one slice handled per clock.
// Optional feature macro: CMP_EARLY_EXIT_EN. When it is defined, the scan
// stops at the first unequal slice. When it is not defined, every slice is
// always scanned, and a sticky 'decided' flag keeps the first unequal result.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  input  logic             slice_gt,
  input  logic             slice_eq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             busy
);

  localparam int NSL   = WIDTH / 2;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               gt_q, eq_q, lt_q;

  logic               finish;
  logic               res_gt, res_eq, res_lt;

`ifndef CMP_EARLY_EXIT_EN
  logic               dec_q, dgt_q;
  logic               res_dec;
`endif

  // Work out this cycle's slice verdict and whether the scan ends here.
  always_comb begin
`ifdef CMP_EARLY_EXIT_EN
    finish  = ~slice_eq | (idx_q == '0);
    res_gt  = ~slice_eq & slice_gt;
    res_eq  = slice_eq;
`else
    // An earlier unequal slice wins. The current slice only matters while undecided.
    finish  = (idx_q == '0);
    res_dec = dec_q | ~slice_eq;
    res_gt  = dec_q ? dgt_q : (~slice_eq & slice_gt);
    res_eq  = ~res_dec;
`endif
    res_lt  = ~res_eq & ~res_gt;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (finish)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and registers.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    slice_a   = a_q[{idx_q, 1'b0} +: 2];
    slice_b   = b_q[{idx_q, 1'b0} +: 2];
    gt        = gt_q;
    eq        = eq_q;
    lt        = lt_q;
  end

  // Datapath: operand capture, slice index, and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      gt_q  <= 1'b0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      dec_q <= 1'b0;
      dgt_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            idx_q <= IDX_W'(NSL - 1);
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            dec_q <= 1'b0;
            dgt_q <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifndef CMP_EARLY_EXIT_EN
          dec_q <= res_dec;
          dgt_q <= res_gt;
`endif
          if (finish) begin
            gt_q <= res_gt;
            eq_q <= res_eq;
            lt_q <= res_lt;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Testbench for serial_cmp_ctrl (WIDTH=8). It supplies the external 2-bit
// comparator and keeps a transaction-level model of the expected result and
// latency. A per-cycle compare process checks the DUT against that model.
module tb_serial_cmp_ctrl;

  localparam int WIDTH = 8;
  localparam int NSL   = 4;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       in_ready, out_valid, gt, eq, lt, busy;
  logic [1:0] slice_a, slice_b;
  logic       slice_gt, slice_eq;

  always #5 clk = ~clk;

  // External comparator slice.
  assign slice_gt = (slice_a > slice_b);
  assign slice_eq = (slice_a == slice_b);

  serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .slice_a(slice_a), .slice_b(slice_b),
    .slice_gt(slice_gt), .slice_eq(slice_eq),
    .out_valid(out_valid), .out_ready(out_ready),
    .gt(gt), .eq(eq), .lt(lt), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Number of slices examined, derived from the operands alone.
  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
    int k;
    logic [7:0] dx, dy;
    k = NSL;
    for (int i = NSL - 1; i >= 0; i--) begin
      dx = (x >> (2 * i)) & 8'd3;
      dy = (y >> (2 * i)) & 8'd3;
      if (dx != dy) begin
        k = NSL - i;
        break;
      end
    end
    return EE ? k : NSL;
  endfunction

  // Transaction model: 0 idle, 1 scanning, 2 result pending.
  int         m_st = 0;
  int         m_cnt = 0;
  int         m_k = 0;
  logic [7:0] m_a = '0, m_b = '0;
  logic       m_gt = 1'b0, m_eq = 1'b0, m_lt = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_gt = 1'b0; m_eq = 1'b0; m_lt = 1'b0;
    end else begin
      case (m_st)
        0: if (in_valid) begin
             m_a = a; m_b = b;
             m_k = exp_lat(a, b); m_cnt = m_k; m_st = 1;
           end
        1: begin
             m_cnt--;
             if (m_cnt == 0) begin
               m_gt = (m_a > m_b); m_eq = (m_a == m_b); m_lt = (m_a < m_b);
               m_st = 2;
             end
           end
        2: if (out_ready) m_st = 0;
        default: m_st = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp_proc
    int idx;
    if (chk_en) begin
      chk("out_valid", out_valid, (m_st == 2));
      chk("in_ready", in_ready, (m_st == 0));
      chk("busy", busy, (m_st != 0));
      if (m_st == 2) chk("flags", {gt, eq, lt}, {m_gt, m_eq, m_lt});
      if (m_st == 1) begin
        idx = NSL - 1 - (m_k - m_cnt);
        chk("slice_a", slice_a, (m_a >> (2 * idx)) & 8'd3);
        chk("slice_b", slice_b, (m_b >> (2 * idx)) & 8'd3);
      end
    end
  end

  // Call at posedge+#1 in IDLE. Returns with the result pending and out_ready low.
  task automatic op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] exp_f,
                    input int lat, input string nm,
                    output logic [7:0] sa_seq, output logic [7:0] sb_seq);
    int n;
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sa_seq = {6'd0, slice_a};
    sb_seq = {6'd0, slice_b};
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (!out_valid) begin
        sa_seq = {sa_seq[5:0], slice_a};
        sb_seq = {sb_seq[5:0], slice_b};
      end
    end
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_flags"}, {gt, eq, lt}, exp_f);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_out_valid", out_valid, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] sa, sb;
    int acc[$];
    int cyc;
    int l_first;
    l_first = EE ? 1 : 4;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags", {gt, eq, lt}, 3'b000);
    chk("rst_slices", {slice_a, slice_b}, 4'b0000);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // 1: top slice decides, so the result is gt
    op(8'hC5, 8'h45, 3'b100, l_first, "t1", sa, sb);
    release_result();

    // 2: equal operands, every slice scanned
    op(8'hA5, 8'hA5, 3'b010, 4, "t2", sa, sb);
    release_result();

    // 3: the last slice decides, so the result is lt. The slice walk is checked literally.
    op(8'h12, 8'h13, 3'b001, 4, "t3", sa, sb);
    chk("t3_slice_a_seq", sa, 8'h12);
    chk("t3_slice_b_seq", sb, 8'h13);
    release_result();

    // 4: result held while out_ready is low, and a stray in_valid is ignored
    op(8'hC5, 8'h45, 3'b100, l_first, "t4", sa, sb);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin a = 8'hFF; b = 8'h00; in_valid = 1'b1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_flags", {gt, eq, lt}, 3'b100);
      chk("t4_hold_busy", busy, 1'b1);
      chk("t4_hold_in_ready", in_ready, 1'b0);
    end
    release_result();
    chk("t4_busy_after", busy, 1'b0);

    // 5: reset asserted mid-scan, then a clean operation
    a = 8'hA5; b = 8'hA5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 1'b0);
    chk("t5_rst_flags", {gt, eq, lt}, 3'b000);
    chk("t5_rst_in_ready", in_ready, 1'b1);
    chk("t5_rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(8'h40, 8'h3F, 3'b100, l_first, "t5", sa, sb);
    release_result();

    // 6: back-to-back operations, expected spacing k+2 = 6 cycles
    a = 8'hA5; b = 8'hA5; in_valid = 1'b1; out_ready = 1'b1;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc.push_back(cyc);
    end
    in_valid = 1'b0;
    chk("t6_accepts", acc.size(), 4);
    for (int i = 1; i < acc.size(); i++) chk("t6_gap", acc[i] - acc[i-1], 6);
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("t6_idle", in_ready, 1'b1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
